// File: rtl/e310_spi_arbiter_pkg.sv
// Shared E310 core definitions used by the AD9361 SPI bus arbiter:
// FSM state encoding, counter widths and default timing constants.
package e310_core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  localparam int unsigned CONFLICT_W     = 16;
  localparam int unsigned TIMEOUT_W      = 20;
  localparam int unsigned GAP_W          = 8;
  localparam int unsigned GAP_CYCLES_DEF = 4;
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES_DEF = 20'd1000000;

  // Requester index width for 2..4 masters.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 2) ? 2 : 1;
  endfunction

endpackage

// File: rtl/e310_spi_arbiter_if.sv
// Request/grant handshake and SPI bus signals between the db_control
// masters, the arbiter and the AD9361 pins.
interface e310_spi_arbiter_if #(
  parameter int unsigned NUM_REQ = 2
);
  import e310_core_pkg::*;

  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    sen_in;
  logic [NUM_REQ-1:0]    sclk_in;
  logic [NUM_REQ-1:0]    mosi_in;
  logic [NUM_REQ-1:0]    miso_out;
  logic                  spi_sen;
  logic                  spi_sclk;
  logic                  spi_mosi;
  logic                  spi_miso;
  logic                  busy;
  logic                  timeout_stb;
  logic [CONFLICT_W-1:0] conflict_count;

  modport slave (
    input  req, sen_in, sclk_in, mosi_in, spi_miso,
    output gnt, miso_out, spi_sen, spi_sclk, spi_mosi, busy, timeout_stb,
           conflict_count
  );

  modport master (
    output req, sen_in, sclk_in, mosi_in, spi_miso,
    input  gnt, miso_out, spi_sen, spi_sclk, spi_mosi, busy, timeout_stb,
           conflict_count
  );

endinterface

// File: rtl/e310_spi_arbiter_rr_pick.sv
// Combinational round-robin selector: the first request strictly above the
// last owner wins, wrapping around to index 0.
module rr_pick
  import e310_core_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] winner,
  output logic               valid
);

  // Two passes (above last, then wrap) avoid a modulo in the search.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!valid && (i > 32'(last)) && req[i]) begin
        winner[i] = 1'b1;
        valid     = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!valid && (i <= 32'(last)) && req[i]) begin
        winner[i] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/e310_spi_arbiter.sv
// AD9361 SPI bus arbiter: round-robin grant held for a whole transaction,
// enforced inter-transaction gap, stuck-owner timeout and violation counter.
module e310_spi_arbiter
  import e310_core_pkg::*;
#(
  parameter int unsigned          NUM_REQ        = 2,
  parameter int unsigned          GAP_CYCLES     = GAP_CYCLES_DEF,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                bus_clk,
  input  logic                bus_rst,
  e310_spi_arbiter_if.slave   bus
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);

  arb_state_e            state_q, state_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [IDX_W-1:0]      last_q, last_d;
  logic [NUM_REQ-1:0]    lockout_q, lockout_d;
  logic [TIMEOUT_W-1:0]  tcnt_q, tcnt_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic                  spi_sen_q, spi_sen_d;
  logic                  spi_sclk_q, spi_sclk_d;
  logic                  spi_mosi_q, spi_mosi_d;
  logic [CONFLICT_W-1:0] conflict_q, conflict_d;

  logic [NUM_REQ-1:0]    eligible;
  logic [NUM_REQ-1:0]    pick_onehot;
  logic                  pick_valid;
  logic [IDX_W-1:0]      pick_idx;
  logic                  timeout_hit;
  logic                  violation;

  assign eligible = bus.req & ~lockout_q;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req    (eligible),
    .last   (last_q),
    .winner (pick_onehot),
    .valid  (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_onehot[i]) pick_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    lockout_d   = lockout_q & bus.req;
    tcnt_d      = tcnt_q;
    gap_cnt_d   = gap_cnt_q;
    spi_sen_d   = 1'b1;
    spi_sclk_d  = 1'b0;
    spi_mosi_d  = 1'b0;
    timeout_hit = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_OWN;
          gnt_d   = pick_onehot;
          last_d  = pick_idx;
          tcnt_d  = '0;
        end
      end
      ST_OWN: begin
        // last_q holds the current owner for the whole OWN period.
        timeout_hit = (TIMEOUT_CYCLES != '0) && (tcnt_q == TIMEOUT_CYCLES);
        if (timeout_hit) begin
          state_d           = ST_GAP;
          gnt_d             = '0;
          gap_cnt_d         = '0;
          lockout_d[last_q] = 1'b1;
        end else if (!bus.req[last_q] && bus.sen_in[last_q]) begin
          state_d   = ST_GAP;
          gnt_d     = '0;
          gap_cnt_d = '0;
        end else begin
          spi_sen_d  = bus.sen_in[last_q];
          spi_sclk_d = bus.sclk_in[last_q];
          spi_mosi_d = bus.mosi_in[last_q];
          tcnt_d     = tcnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // One increment per offending cycle regardless of how many masters offend.
  always_comb begin
    violation  = |(~bus.sen_in & ~gnt_q);
    conflict_d = conflict_q;
    if (violation && (conflict_q != '1)) conflict_d = conflict_q + 1'b1;
  end

  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      last_q     <= IDX_W'(NUM_REQ - 1);
      lockout_q  <= '0;
      tcnt_q     <= '0;
      gap_cnt_q  <= '0;
      spi_sen_q  <= 1'b1;
      spi_sclk_q <= 1'b0;
      spi_mosi_q <= 1'b0;
      conflict_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      lockout_q  <= lockout_d;
      tcnt_q     <= tcnt_d;
      gap_cnt_q  <= gap_cnt_d;
      spi_sen_q  <= spi_sen_d;
      spi_sclk_q <= spi_sclk_d;
      spi_mosi_q <= spi_mosi_d;
      conflict_q <= conflict_d;
    end
  end

  assign bus.gnt            = gnt_q;
  assign bus.miso_out       = gnt_q & {NUM_REQ{bus.spi_miso}};
  assign bus.spi_sen        = spi_sen_q;
  assign bus.spi_sclk       = spi_sclk_q;
  assign bus.spi_mosi       = spi_mosi_q;
  assign bus.busy           = (state_q != ST_IDLE);
  assign bus.timeout_stb    = timeout_hit;
  assign bus.conflict_count = conflict_q;

endmodule
